// File: rtl/alu_seq.sv
// Sequenced switch/button ALU: A, B, then opcode; result and flags registered.
// Optional ALU_BTN_SYNC_EN adds a two-flop synchronizer on each button.
module alu_seq #(
    parameter int BUS_SIZE    = 8,
    parameter int OPCODE_SIZE = 6,
    parameter int SHAMT_SIZE  = $clog2(BUS_SIZE)
) (
    input  logic                i_clock,
    input  logic                i_reset_n,
    input  logic [BUS_SIZE-1:0] i_switches,
    input  logic                i_button1,
    input  logic                i_button2,
    input  logic                i_button3,
    output logic [BUS_SIZE-1:0] o_result,
    output logic                o_carry,
    output logic                o_overflow,
    output logic                o_zero,
    output logic                o_error,
    output logic                o_valid,
    output logic [1:0]          o_state
);

    typedef enum logic [1:0] {
        WAIT_A  = 2'd0,
        WAIT_B  = 2'd1,
        WAIT_OP = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [OPCODE_SIZE-1:0] OP_ADD  = OPCODE_SIZE'(6'b100000);
    localparam logic [OPCODE_SIZE-1:0] OP_SUB  = OPCODE_SIZE'(6'b100010);
    localparam logic [OPCODE_SIZE-1:0] OP_AND  = OPCODE_SIZE'(6'b100100);
    localparam logic [OPCODE_SIZE-1:0] OP_OR   = OPCODE_SIZE'(6'b100101);
    localparam logic [OPCODE_SIZE-1:0] OP_XOR  = OPCODE_SIZE'(6'b100110);
    localparam logic [OPCODE_SIZE-1:0] OP_NOR  = OPCODE_SIZE'(6'b100111);
    localparam logic [OPCODE_SIZE-1:0] OP_SRL  = OPCODE_SIZE'(6'b000010);
    localparam logic [OPCODE_SIZE-1:0] OP_SRA  = OPCODE_SIZE'(6'b000011);
    localparam logic [OPCODE_SIZE-1:0] OP_SLL  = OPCODE_SIZE'(6'b000000);
    localparam logic [OPCODE_SIZE-1:0] OP_SLT  = OPCODE_SIZE'(6'b101010);
    localparam logic [OPCODE_SIZE-1:0] OP_SLTU = OPCODE_SIZE'(6'b101011);

    function automatic logic op_known(input logic [OPCODE_SIZE-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR,
            OP_SRL, OP_SRA, OP_SLL, OP_SLT, OP_SLTU: op_known = 1'b1;
            default:                                 op_known = 1'b0;
        endcase
    endfunction

    state_t                 state_q, state_d;
    logic [BUS_SIZE-1:0]    a_q, b_q, result_q;
    logic [OPCODE_SIZE-1:0] op_q;
    logic                   carry_q, ovf_q, zero_q, valid_q;
    logic [2:0]             btn_raw, btn, btn_q, rise;
    logic                   ld_a, ld_b, exec;

    assign btn_raw = {i_button3, i_button2, i_button1};

`ifdef ALU_BTN_SYNC_EN
    logic [2:0] sync1_q, sync2_q;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    assign btn = sync2_q;
`else
    assign btn = btn_raw;
`endif

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) btn_q <= '0;
        else            btn_q <= btn;
    end

    assign rise = btn & ~btn_q;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) state_q <= WAIT_A;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ld_a    = 1'b0;
        ld_b    = 1'b0;
        exec    = 1'b0;
        unique case (state_q)
            WAIT_A: if (rise[0]) begin
                ld_a    = 1'b1;
                state_d = WAIT_B;
            end
            WAIT_B: if (rise[1]) begin
                ld_b    = 1'b1;
                state_d = WAIT_OP;
            end
            WAIT_OP: if (rise[2]) begin
                exec    = 1'b1;
                state_d = DONE;
            end
            DONE: if (rise[0]) begin
                ld_a    = 1'b1;
                state_d = WAIT_B;
            end
            default: state_d = WAIT_A;
        endcase
    end

    // The opcode is taken live from the switches in the executing cycle.
    logic [OPCODE_SIZE-1:0] op;
    logic [SHAMT_SIZE-1:0]  shamt;
    logic [BUS_SIZE:0]      sum, diff;
    logic [BUS_SIZE-1:0]    alu_res;
    logic                   alu_c, alu_v, sa, sb;

    assign op    = i_switches[OPCODE_SIZE-1:0];
    assign shamt = b_q[SHAMT_SIZE-1:0];
    assign sum   = {1'b0, a_q} + {1'b0, b_q};
    assign diff  = {1'b0, a_q} - {1'b0, b_q};
    assign sa    = a_q[BUS_SIZE-1];
    assign sb    = b_q[BUS_SIZE-1];

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        unique case (op)
            OP_ADD: begin
                alu_res = sum[BUS_SIZE-1:0];
                alu_c   = sum[BUS_SIZE];
                alu_v   = (sa == sb) && (sum[BUS_SIZE-1] != sa);
            end
            OP_SUB: begin
                alu_res = diff[BUS_SIZE-1:0];
                alu_c   = diff[BUS_SIZE];
                alu_v   = (sa != sb) && (diff[BUS_SIZE-1] != sa);
            end
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_NOR:  alu_res = ~(a_q | b_q);
            OP_SRL:  alu_res = a_q >> shamt;
            OP_SRA:  alu_res = $signed(a_q) >>> shamt;
            OP_SLL:  alu_res = a_q << shamt;
            OP_SLT:  alu_res = {{(BUS_SIZE-1){1'b0}},
                                ($signed(a_q) < $signed(b_q))};
            OP_SLTU: alu_res = {{(BUS_SIZE-1){1'b0}}, (a_q < b_q)};
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            if (ld_a) a_q <= i_switches;
            if (ld_b) b_q <= i_switches;
            if (exec) begin
                op_q     <= op;
                result_q <= alu_res;
                carry_q  <= alu_c;
                ovf_q    <= alu_v;
                zero_q   <= (alu_res == '0);
            end
            if (exec)      valid_q <= 1'b1;
            else if (ld_a) valid_q <= 1'b0;
        end
    end

    assign o_result   = result_q;
    assign o_carry    = carry_q;
    assign o_overflow = ovf_q;
    assign o_zero     = zero_q;
    assign o_error    = ~op_known(op_q);
    assign o_valid    = valid_q;
    assign o_state    = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq; works with or without ALU_BTN_SYNC_EN.
module tb_alu_seq;

`ifdef ALU_BTN_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] sw = '0;
    logic       b1 = 1'b0, b2 = 1'b0, b3 = 1'b0;
    logic [7:0] o_result;
    logic       o_carry, o_overflow, o_zero, o_error, o_valid;
    logic [1:0] o_state;

    alu_seq dut (
        .i_clock    (clk),
        .i_reset_n  (rst_n),
        .i_switches (sw),
        .i_button1  (b1),
        .i_button2  (b2),
        .i_button3  (b3),
        .o_result   (o_result),
        .o_carry    (o_carry),
        .o_overflow (o_overflow),
        .o_zero     (o_zero),
        .o_error    (o_error),
        .o_valid    (o_valid),
        .o_state    (o_state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] r;
        logic       c, v, z, e;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] r, input logic c,
                                input logic v, input logic z,
                                input logic e);
        exp_t x;
        x.r = r; x.c = c; x.v = v; x.z = z; x.e = e;
        return x;
    endfunction

    logic v_prev = 1'b0;

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst_n) begin
            v_prev = 1'b0;
        end else begin
            if (o_valid && !v_prev) begin
                if (q.size() == 0) begin
                    chk("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("result", 32'(o_result), 32'(e.r));
                    chk("carry", 32'(o_carry), 32'(e.c));
                    chk("overflow", 32'(o_overflow), 32'(e.v));
                    chk("zero", 32'(o_zero), 32'(e.z));
                    chk("error", 32'(o_error), 32'(e.e));
                end
            end
            v_prev = o_valid;
        end
    end

    task automatic press(input int n, input logic [7:0] v);
        @(negedge clk);
        sw = v;
        case (n)
            1:       b1 = 1'b1;
            2:       b2 = 1'b1;
            default: b3 = 1'b1;
        endcase
        @(negedge clk);
        b1 = 1'b0; b2 = 1'b0; b3 = 1'b0;
        repeat (LAT) @(negedge clk);
    endtask

    task automatic run_bo(input logic [7:0] b, input logic [7:0] op,
                          input exp_t x);
        press(2, b);
        chk("valid_before_exec", 32'(o_valid), 32'd0);
        q.push_back(x);
        press(3, op);
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            chk("sb_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
        chk("state_done", 32'(o_state), 32'd3);
        chk("valid_done", 32'(o_valid), 32'd1);
    endtask

    task automatic run(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] op, input exp_t x);
        press(1, a);
        run_bo(b, op, x);
    endtask

    task automatic reset_in_wait_op();
        press(1, 8'h10);
        press(2, 8'h20);
        chk("state_wait_op", 32'(o_state), 32'd2);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_state", 32'(o_state), 32'd0);
        chk("rst_result", 32'(o_result), 32'd0);
        chk("rst_flags", 32'({o_carry, o_overflow, o_zero, o_error}), 32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        chk("reset_state", 32'(o_state), 32'd0);
        chk("reset_result", 32'(o_result), 32'd0);
        chk("reset_flags", 32'({o_carry, o_overflow, o_zero, o_error}), 32'd0);
        chk("reset_valid", 32'(o_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        press(3, 8'h20);
        chk("btn3_in_wait_a", 32'(o_state), 32'd0);

        run(8'hFF, 8'h01, 8'h20, mk(8'h00, 1'b1, 1'b0, 1'b1, 1'b0));
        run(8'h80, 8'h01, 8'h22, mk(8'h7F, 1'b0, 1'b1, 1'b0, 1'b0));
        run(8'h01, 8'h02, 8'h22, mk(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0));
        run(8'h90, 8'h02, 8'h03, mk(8'hE4, 1'b0, 1'b0, 1'b0, 1'b0));
        run(8'h90, 8'h02, 8'h02, mk(8'h24, 1'b0, 1'b0, 1'b0, 1'b0));
        run(8'h90, 8'h02, 8'h00, mk(8'h40, 1'b0, 1'b0, 1'b0, 1'b0));
        run(8'h90, 8'h02, 8'h2A, mk(8'h01, 1'b0, 1'b0, 1'b0, 1'b0));
        run(8'h90, 8'h02, 8'h2B, mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b0));
        run(8'hF0, 8'h3C, 8'h24, mk(8'h30, 1'b0, 1'b0, 1'b0, 1'b0));
        run(8'hF0, 8'h3C, 8'h25, mk(8'hFC, 1'b0, 1'b0, 1'b0, 1'b0));
        run(8'hF0, 8'h3C, 8'h26, mk(8'hCC, 1'b0, 1'b0, 1'b0, 1'b0));
        run(8'hF0, 8'h3C, 8'h27, mk(8'h03, 1'b0, 1'b0, 1'b0, 1'b0));
        run(8'h7F, 8'h01, 8'h20, mk(8'h80, 1'b0, 1'b1, 1'b0, 1'b0));
        run(8'h55, 8'h11, 8'h3F, mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b1));

        press(1, 8'h42);
        chk("done_b1_valid", 32'(o_valid), 32'd0);
        chk("done_b1_state", 32'(o_state), 32'd1);
        chk("done_b1_error_held", 32'(o_error), 32'd1);

        press(2, 8'h01);
        chk("state_wait_op2", 32'(o_state), 32'd2);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_state_a", 32'(o_state), 32'd0);
        chk("rst_error_a", 32'(o_error), 32'd0);
        chk("rst_zero_a", 32'(o_zero), 32'd0);

        @(negedge clk);
        sw = 8'h05;
        b1 = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT) @(negedge clk);
        chk("held_b1_pre", 32'(o_state), 32'd0);
        @(negedge clk);
        chk("held_b1_after_rst", 32'(o_state), 32'd1);
        b1 = 1'b0;
        run_bo(8'h03, 8'h20, mk(8'h08, 1'b0, 1'b0, 1'b0, 1'b0));

        @(negedge clk);
        b1 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sw = 8'h11 + 8'(i);
            @(negedge clk);
        end
        b1 = 1'b0;
        repeat (LAT) @(negedge clk);
        chk("hold_state", 32'(o_state), 32'd1);
        run_bo(8'h01, 8'h20,
               mk(8'h12 + 8'(LAT), 1'b0, 1'b0, 1'b0, 1'b0));

        reset_in_wait_op();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
